// File: rtl/rv32i_pkg.sv
// Shared RV32 fetch definitions: default widths, reset PC and the fetch entry layout.
package rv32i_pkg;

  localparam int unsigned WIDTH_DEF    = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned FETCH_DEPTH  = 2;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] inst;
    logic [WIDTH_DEF-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/rv32i_fetch_ctrl_if.sv
// Fetch controller bus: instruction memory port, decoder handshake and EX redirect/halt.
interface rv32i_fetch_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] o_imem_addr;
  logic             o_imem_req;
  logic [WIDTH-1:0] i_imem_inst;
  logic [WIDTH-1:0] o_inst;
  logic [WIDTH-1:0] o_inst_pc;
  logic             o_inst_valid;
  logic             i_inst_ready;
  logic             i_redirect;
  logic [WIDTH-1:0] i_redirect_pc;
  logic             i_halt;

  modport master (
    output o_imem_addr, o_imem_req, o_inst, o_inst_pc, o_inst_valid,
    input  i_imem_inst, i_inst_ready, i_redirect, i_redirect_pc, i_halt
  );

  modport slave (
    input  o_imem_addr, o_imem_req, o_inst, o_inst_pc, o_inst_valid,
    output i_imem_inst, i_inst_ready, i_redirect, i_redirect_pc, i_halt
  );
endinterface

// File: rtl/rv32i_fetch_fifo.sv
// Two-entry skid FIFO of {inst, pc}; clear beats push/pop, simultaneous push and pop allowed.
module rv32i_fetch_fifo
  import rv32i_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [FETCH_DEPTH];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         do_push, do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'(FETCH_DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FETCH_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/rv32i_fetch_ctrl.sv
// RV32 fetch controller: PC, imem request issue, response capture and redirect flush.
// Optional RV32I_FETCH_PERF_EN adds fetch/stall event counters.
module rv32i_fetch_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned      WIDTH    = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  rv32i_fetch_ctrl_if.master       bus
`ifdef RV32I_FETCH_PERF_EN
  ,
  output logic [WIDTH-1:0]         o_fetch_cnt,
  output logic [WIDTH-1:0]         o_stall_cnt
`endif
);

  logic [WIDTH-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
  logic [WIDTH-1:0] target, imem_addr;
  logic             inflight_q, inflight_d, drop_q, drop_d;
  logic             issue, push, pop, pop_raw, redirect;
  logic [1:0]       fifo_cnt;
  logic [2:0]       occ;
  logic             fifo_full, fifo_empty;
  fetch_entry_t     head, wentry;
  logic             unused_ok;

  // Redirect and issue are masked while reset is held so outputs sit at reset values.
  assign redirect = rst & bus.i_redirect;
  assign target   = {bus.i_redirect_pc[WIDTH-1:2], 2'b00};
  assign pop_raw  = ~fifo_empty & bus.i_inst_ready;
  assign pop      = pop_raw & ~redirect;
  assign push     = inflight_q & ~drop_q & ~redirect;
  assign occ      = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop_raw};
  assign wentry   = '{inst: bus.i_imem_inst, pc: inflight_pc_q};

  always_comb begin
    issue         = 1'b0;
    imem_addr     = pc_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    drop_d        = 1'b0;
    if (redirect) begin
      issue     = ~bus.i_halt;
      imem_addr = target;
      pc_d      = issue ? target + WIDTH'(4) : target;
      drop_d    = inflight_q & ~issue;
    end else begin
      issue = rst & ~bus.i_halt & (occ < 3'd2);
      if (issue) pc_d = pc_q + WIDTH'(4);
    end
    inflight_d = issue;
    if (issue) inflight_pc_d = imem_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      drop_q        <= drop_d;
    end
  end

  rv32i_fetch_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect),
    .wdata_i (wentry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign bus.o_imem_req   = issue;
  assign bus.o_imem_addr  = imem_addr;
  assign bus.o_inst       = head.inst;
  assign bus.o_inst_pc    = head.pc;
  assign bus.o_inst_valid = ~fifo_empty;
  assign unused_ok        = ^{bus.i_redirect_pc[1:0], fifo_full};

`ifdef RV32I_FETCH_PERF_EN
  logic [WIDTH-1:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + WIDTH'(push);
      stall_cnt_q <= stall_cnt_q + WIDTH'(~fifo_empty & ~bus.i_inst_ready);
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// Bench for rv32i_fetch_ctrl: directed scenarios plus random traffic against a queue-based fetch model.
module tb_rv32i_fetch_ctrl;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  rv32i_fetch_ctrl_if #(.WIDTH(32)) bus ();
`ifdef RV32I_FETCH_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  rv32i_fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RV32I_FETCH_PERF_EN
    ,
    .o_fetch_cnt (fetch_cnt),
    .o_stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  // Synchronous instruction memory: data for a request appears the next cycle.
  logic [31:0] imem_q = '0;
  always @(posedge clk) if (bus.o_imem_req) imem_q <= mem_word(bus.o_imem_addr);
  assign bus.i_imem_inst = imem_q;

  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t        q[$];
  bit          m_inflight;
  logic [31:0] m_pc, m_ipc;
  int          m_reqs, m_fetch, m_stall;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_addr, last_pc;
  logic        last_req, last_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_inflight = 0;
    m_pc = 32'h0;
    m_ipc = 32'h0;
    m_reqs = 0;
    m_fetch = 0;
    m_stall = 0;
  endtask

  task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc, input bit hlt);
    bit          exp_req, exp_valid;
    logic [31:0] exp_addr, tgt;
    int          occ;
    bus.i_inst_ready  = rdy;
    bus.i_redirect    = rd;
    bus.i_redirect_pc = rpc;
    bus.i_halt        = hlt;
    #2;
`ifdef RV32I_FETCH_PERF_EN
    chk("fetch_cnt", fetch_cnt, m_fetch);
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    exp_valid = (q.size() != 0);
    tgt = rpc & 32'hFFFF_FFFC;
    if (rd) begin
      exp_req  = !hlt;
      exp_addr = tgt;
    end else begin
      occ      = q.size() + int'(m_inflight) - int'(exp_valid && rdy);
      exp_req  = !hlt && (occ < 2);
      exp_addr = m_pc;
    end
    chk("inst_valid", 32'(bus.o_inst_valid), 32'(exp_valid));
    chk("imem_req", 32'(bus.o_imem_req), 32'(exp_req));
    chk("imem_addr", bus.o_imem_addr, exp_addr);
    if (exp_valid) begin
      chk("inst", bus.o_inst, q[0].inst);
      chk("inst_pc", bus.o_inst_pc, q[0].pc);
    end
    last_addr  = bus.o_imem_addr;
    last_pc    = bus.o_inst_pc;
    last_req   = bus.o_imem_req;
    last_valid = bus.o_inst_valid;

    if (exp_valid && !rdy) m_stall++;
    if (rd) begin
      q.delete();
      m_pc = hlt ? tgt : tgt + 32'd4;
    end else begin
      if (exp_valid && rdy) void'(q.pop_front());
      if (m_inflight) begin
        q.push_back('{inst: mem_word(m_ipc), pc: m_ipc});
        m_fetch++;
      end
      if (exp_req) m_pc = m_pc + 32'd4;
    end
    if (exp_req) begin
      m_ipc = exp_addr;
      m_reqs++;
    end
    m_inflight = exp_req;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.o_inst_valid), 32'd0);
    chk({tag, "_inst"}, bus.o_inst, 32'd0);
    chk({tag, "_inst_pc"}, bus.o_inst_pc, 32'd0);
    chk({tag, "_req"}, 32'(bus.o_imem_req), 32'd0);
    chk({tag, "_addr"}, bus.o_imem_addr, 32'h0);
  endtask

  initial begin
    bus.i_inst_ready  = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_halt        = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("rst_init");
    @(negedge clk);
    rst = 1'b1;

    // Start-up and steady stream.
    step(1, 0, 0, 0);
    chk("first_req_addr", last_addr, 32'h0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("first_valid", 32'(last_valid), 32'd1);
    chk("first_valid_pc", last_pc, 32'h0);
    for (int i = 3; i < 5; i++) step(1, 0, 0, 0);
    // Decoder stall cycles 5..9.
    for (int i = 5; i < 10; i++) begin
      step(0, 0, 0, 0);
      if (i >= 7) chk("stall_noreq", 32'(last_req), 32'd0);
    end
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

    // Redirect with two entries buffered.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 32'h100, 0);
    step(1, 0, 0, 0);
    chk("redir_valid_drop", 32'(last_valid), 32'd0);
    step(1, 0, 0, 0);
    chk("redir_target_pc", last_pc, 32'h100);
    // Redirect from steady state with a request in flight, simultaneous pop.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 1, 32'h103, 0);
    chk("redir_align", last_addr, 32'h100);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

    // Halt with one in flight, redirect during halt, release.
    step(1, 0, 0, 1);
    chk("halt_noreq", 32'(last_req), 32'd0);
    step(1, 0, 0, 1);
    step(1, 1, 32'h40, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    chk("halt_resume_addr", last_addr, 32'h40);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

    // PC wrap at the top of the address space.
    step(1, 1, 32'hFFFF_FFFE, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom,
           $urandom_range(0, 9) == 0);

    // Mid-stream reset with valid high.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    chk("pre_rst_valid", 32'(last_valid), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Ten fetches with three stall cycles, then halt and drain.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    for (int j = 0; j < 50 && m_reqs < 10; j++) step(1, 0, 0, 0);
    chk("req_budget", m_reqs, 32'd10);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
`ifdef RV32I_FETCH_PERF_EN
    chk("perf_fetch_10", fetch_cnt, 32'd10);
    chk("perf_stall_3", stall_cnt, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
